// File: rtl/croc_pkg.sv
// Shared types and constants for the core data-side guard.
package croc_pkg;

    typedef enum logic [1:0] {GUARD_IDLE, GUARD_WAIT, GUARD_ERR} guard_state_e;

    localparam logic [31:0] GuardErrRdata      = 32'hBADCAB1E;
    localparam int unsigned GuardTimeoutCycles = 256;

endpackage

// File: rtl/core_data_guard_timer.sv
// Response-latency timer: loadable up-counter with synchronous clear, enable and a limit-hit flag.
module core_data_guard_timer #(
    parameter int unsigned Limit = 256,
    localparam int unsigned W = $clog2(Limit)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         limit_hit
);

    localparam logic [W-1:0] LastCount = W'(Limit - 1);

    logic [W-1:0] count;

    // Clear has priority so a restart can never be masked by a stray enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign limit_hit = (count == LastCount);

endmodule

// File: rtl/core_data_guard.sv
// Data-port guard: caps outstanding transactions and retires hung ones with a poisoned error response.
// Optional timeout statistics counter is built when CORE_DATA_GUARD_STATS_EN is defined.
module core_data_guard
    import croc_pkg::*;
#(
    parameter int unsigned TimeoutCycles  = GuardTimeoutCycles,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ErrRdata       = GuardErrRdata
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        timeout_irq_o,
    output logic [15:0] timeout_cnt_o
);

    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned TimerW  = $clog2(TimeoutCycles);
    localparam logic [CntW:0] Limit = (CntW + 1)'(MaxOutstanding);

    guard_state_e state, state_next;

    logic [CntW-1:0] live, live_next;
    logic [CntW-1:0] stale, stale_next;
    logic            full, handshake, swallow, forward, in_err, deliver, stale_inc;
    logic            timer_clear, timer_en, timer_hit;

    assign full      = ({1'b0, live} + {1'b0, stale}) == Limit;
    assign mem_req_o = core_req_i & ~full;
    assign core_gnt_o = mem_gnt_i & mem_req_o;
    assign handshake = core_gnt_o;

    assign mem_we_o    = core_we_i;
    assign mem_be_o    = core_be_i;
    assign mem_addr_o  = core_addr_i;
    assign mem_wdata_o = core_wdata_i;

    // Stale responses sit ahead of live ones, so any rvalid while stale>0 belongs to a retired transaction.
    assign in_err  = (state == GUARD_ERR);
    assign swallow = mem_rvalid_i & (stale != '0);
    assign forward = mem_rvalid_i & (stale == '0) & ~in_err;
    assign deliver = forward | in_err;

    // A response racing the retirement is the timed-out one itself, so nothing is left to swallow later.
    assign stale_inc = in_err & ~(mem_rvalid_i & (stale == '0));

    assign core_rvalid_o = deliver;
    assign core_err_o    = in_err | (forward & mem_err_i);
    assign core_rdata_o  = in_err ? ErrRdata : (forward ? mem_rdata_i : '0);
    assign timeout_irq_o = in_err;

    always_comb begin
        live_next  = live;
        stale_next = stale;
        if (handshake && !deliver) begin
            live_next = live + CntW'(1);
        end else if (!handshake && deliver) begin
            live_next = live - CntW'(1);
        end
        if (stale_inc && !swallow) begin
            stale_next = stale + CntW'(1);
        end else if (!stale_inc && swallow) begin
            stale_next = stale - CntW'(1);
        end
    end

    // The timer only runs in WAIT; every exit or delivered response restarts it from zero.
    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state)
            GUARD_IDLE: begin
                timer_clear = 1'b1;
                if (handshake) begin
                    state_next = GUARD_WAIT;
                end
            end
            GUARD_WAIT: begin
                if (forward) begin
                    timer_clear = 1'b1;
                    if (live_next == '0) begin
                        state_next = GUARD_IDLE;
                    end
                end else if (timer_hit) begin
                    timer_clear = 1'b1;
                    state_next  = GUARD_ERR;
                end else begin
                    timer_en = 1'b1;
                end
            end
            GUARD_ERR: begin
                timer_clear = 1'b1;
                state_next  = (live_next != '0) ? GUARD_WAIT : GUARD_IDLE;
            end
            default: begin
                timer_clear = 1'b1;
                state_next  = GUARD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= GUARD_IDLE;
            live  <= '0;
            stale <= '0;
        end else begin
            state <= state_next;
            live  <= live_next;
            stale <= stale_next;
        end
    end

    core_data_guard_timer #(
        .Limit (TimeoutCycles)
    ) u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ({TimerW{1'b0}}),
        .enable     (timer_en),
        .limit_hit  (timer_hit)
    );

`ifdef CORE_DATA_GUARD_STATS_EN
    logic [15:0] timeout_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_cnt <= '0;
        end else if (in_err && timeout_cnt != 16'hFFFF) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

    assign timeout_cnt_o = timeout_cnt;
`else
    assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_data_guard.sv
// Self-checking bench for core_data_guard: directed scenarios plus random traffic against a
// transaction-queue reference model (each in-flight memory transaction tagged live or stale).
module tb_core_data_guard;

    localparam int unsigned T_OUT   = 16;
    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] POISON  = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_gnt, core_we, core_rvalid, core_err;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        timeout_irq;
    logic [15:0] timeout_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: memory-side transactions in issue order, 1 = already retired (stale).
    bit memq[$];
    int cyc        = 0;
    int deadline   = 0;
    int tcnt_model = 0;

    always #5 clk = ~clk;

    core_data_guard #(
        .TimeoutCycles  (T_OUT),
        .MaxOutstanding (MAX_OUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .core_req_i    (core_req),
        .core_gnt_o    (core_gnt),
        .core_we_i     (core_we),
        .core_be_i     (core_be),
        .core_addr_i   (core_addr),
        .core_wdata_i  (core_wdata),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .core_err_o    (core_err),
        .mem_req_o     (mem_req),
        .mem_gnt_i     (mem_gnt),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .timeout_irq_o (timeout_irq),
        .timeout_cnt_o (timeout_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic gnt, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rvalid, input logic [31:0] rdata, input logic err);
        core_req   = req;
        mem_gnt    = gnt;
        core_we    = we;
        core_be    = be;
        core_addr  = addr;
        core_wdata = wdata;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
        mem_err    = err;
    endtask

    function automatic int staleCount();
        int n = 0;
        foreach (memq[i]) if (memq[i]) n++;
        return n;
    endfunction

    // Checks one cycle against the model, then advances the model and the clock.
    task automatic cycleStep();
        int          live_before, stale_before, live_after;
        bit          hs, err_now, delivered, marked;
        logic        e_req, e_gnt, e_rv, e_err, e_irq;
        logic [31:0] e_rdata;
        logic [15:0] e_cnt;

        @(negedge clk);
        stale_before = staleCount();
        live_before  = memq.size() - stale_before;
        e_req   = core_req & (memq.size() != MAX_OUT);
        e_gnt   = e_req & mem_gnt;
        hs      = e_gnt;
        err_now = (live_before > 0) && (cyc == deadline);
        e_rv    = 1'b0;
        e_err   = 1'b0;
        e_irq   = 1'b0;
        e_rdata = '0;
        e_cnt   = 16'(tcnt_model);
        delivered = 1'b0;

        if (err_now) begin
            e_rv = 1'b1; e_err = 1'b1; e_rdata = POISON; e_irq = 1'b1;
            delivered = 1'b1;
            if (mem_rvalid && stale_before == 0) begin
                void'(memq.pop_front());
            end else begin
                if (mem_rvalid) void'(memq.pop_front());
                marked = 1'b0;
                for (int i = 0; i < memq.size(); i++) begin
                    if (!marked && !memq[i]) begin
                        memq[i] = 1'b1;
                        marked  = 1'b1;
                    end
                end
            end
        end else if (mem_rvalid) begin
            if (memq[0]) begin
                void'(memq.pop_front());
            end else begin
                void'(memq.pop_front());
                e_rv = 1'b1; e_rdata = mem_rdata; e_err = mem_err;
                delivered = 1'b1;
            end
        end

        checkOutput("mem_req", mem_req, e_req);
        checkOutput("core_gnt", core_gnt, e_gnt);
        checkOutput("core_rvalid", core_rvalid, e_rv);
        checkOutput("core_err", core_err, e_err);
        checkOutput("core_rdata", core_rdata, e_rdata);
        checkOutput("timeout_irq", timeout_irq, e_irq);
        checkOutput("mem_addr", mem_addr, core_addr);
        checkOutput("mem_fields", {mem_we, mem_be, mem_wdata[26:0]}, {core_we, core_be, core_wdata[26:0]});
`ifdef CORE_DATA_GUARD_STATS_EN
        checkOutput("timeout_cnt", timeout_cnt, e_cnt);
        if (err_now && tcnt_model < 16'hFFFF) tcnt_model++;
`else
        checkOutput("timeout_cnt", timeout_cnt, 32'h0);
`endif

        if (hs) memq.push_back(1'b0);
        live_after = memq.size() - staleCount();
        if (live_after > 0 && (delivered || live_before == 0)) deadline = cyc + 1 + T_OUT;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
            cycleStep();
        end
    endtask

    task automatic readReq(input logic [31:0] addr);
        applyStimulus(1, 1, 0, 4'hF, addr, 32'h0, 0, 32'h0, 0);
        cycleStep();
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, rdata, err);
        cycleStep();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, core_gnt, 0);
        checkOutput({tag, "_rvalid"}, core_rvalid, 0);
        checkOutput({tag, "_rdata"}, core_rdata, 0);
        checkOutput({tag, "_err"}, core_err, 0);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_irq"}, timeout_irq, 0);
        checkOutput({tag, "_cnt"}, timeout_cnt, 0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] read answered after 3 cycles");
        readReq(32'h0000_1000);
        idleCycles(2);
        respond(32'h0000_1234, 0);

        $display("[TB] unanswered read times out");
        readReq(32'h0000_2000);
        idleCycles(16);
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        checkOutput("timeout_err", core_err, 1);
        checkOutput("timeout_rdata", core_rdata, POISON);
        cycleStep();

        $display("[TB] late response swallowed, next read completes");
        respond(32'h0000_DEAD, 0);
        readReq(32'h0000_3000);
        idleCycles(1);
        respond(32'h0000_0055, 1);

        $display("[TB] outstanding cap stalls third request");
        readReq(32'h0000_4000);
        readReq(32'h0000_4004);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 4'h3, 32'h0000_4008, 32'hCAFE_0001, 0, 32'h0, 0);
            cycleStep();
        end
        applyStimulus(1, 1, 1, 4'h3, 32'h0000_4008, 32'hCAFE_0001, 1, 32'h0000_0A0A, 0);
        cycleStep();
        applyStimulus(1, 1, 1, 4'h3, 32'h0000_4008, 32'hCAFE_0001, 0, 32'h0, 0);
        cycleStep();
        respond(32'h0000_0B0B, 0);
        respond(32'h0000_0C0C, 0);

        $display("[TB] response in the limit cycle wins");
        readReq(32'h0000_5000);
        idleCycles(15);
        respond(32'h0000_0077, 0);
        idleCycles(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                          4'($urandom), $urandom, $urandom,
                          (memq.size() > 0) && ($urandom_range(0, 19) == 0), $urandom,
                          1'($urandom_range(0, 7) == 0));
            cycleStep();
        end

        $display("[TB] reset with two outstanding, one stale");
        idleCycles(40);
        for (int i = 0; i < 4; i++) begin
            if (memq.size() > 0) respond(32'h0, 0);
        end
        readReq(32'h0000_6000);
        idleCycles(17);
        readReq(32'h0000_6004);
        checkOutput("pre_reset_inflight", memq.size(), 2);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        #1;
        checkAllZero("midreset");
        memq.delete();
        tcnt_model = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        readReq(32'h0000_7000);
        respond(32'h0000_0099, 0);
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
